// File: rtl/inst_mem_responder.sv
// inst_mem_responder: instruction-fetch responder backed by a word-addressed RAM.
// Accepts one fetch per cycle and returns the 32-bit word after a fixed LATENCY,
// in order. Misaligned or out-of-range fetches return NOP_INST and raise
// inst_fault. The RAM is preloaded through a separate load port, and a load
// takes priority over a fetch in the same cycle.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   inst_ena       fetch request this cycle
//   inst_addr      fetch byte address (64 bits)
//   inst           fetched instruction (holds last delivered value when idle)
//   inst_valid     inst/inst_fault valid this cycle
//   inst_fault     response is for a misaligned or out-of-range address
//   load_ena       write one RAM word this cycle
//   load_addr      word index to write
//   load_data      word to write
//   req_stall      combinational; fetch refused because a load is in progress
//   fetch_cnt      accepted-fetch counter, saturating
module inst_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_ena,
  input  logic [63:0]           inst_addr,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  output logic                  inst_fault,
  input  logic                  load_ena,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  req_stall,
  output logic [31:0]           fetch_cnt
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned DATA_W = 32;

  // Reject unsupported pipeline depths at elaboration.
  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("inst_mem_responder: LATENCY must be in 1..4");
    end
  endgenerate

  logic [63:0]           off;
  logic                  addr_fault;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  accept;

  // Addresses below BASE_ADDR wrap to huge offsets and therefore fault.
  assign off        = inst_addr - BASE_ADDR;
  assign addr_fault = (off[1:0] != 2'b00) || ((off >> (DEPTH_LOG2 + 2)) != 64'd0);
  assign word_idx   = off[DEPTH_LOG2+1:2];

  // A load in the same cycle refuses the fetch.
  assign accept    = inst_ena & ~load_ena;
  assign req_stall = inst_ena & load_ena;

  // Instruction RAM; contents are not reset, and writes are ignored while in reset.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (load_ena && rst) begin
      mem[load_addr] <= load_data;
    end
  end

  // Response pipeline; stage 0 performs the synchronous RAM read, and the last stage drives the outputs.
  logic              pv [LATENCY];
  logic              pf [LATENCY];
  logic [DATA_W-1:0] pd [LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        pv[k] <= 1'b0;
        pf[k] <= 1'b0;
        pd[k] <= '0;
      end
    end else begin
      pv[0] <= accept;
      pf[0] <= accept & addr_fault;
      if (accept) begin
        pd[0] <= addr_fault ? NOP_INST : mem[word_idx];
      end
      // Data only advances with a valid entry, so the output stage holds the last delivered word.
      for (int unsigned k = 1; k < LATENCY; k++) begin
        pv[k] <= pv[k-1];
        pf[k] <= pf[k-1];
        if (pv[k-1]) begin
          pd[k] <= pd[k-1];
        end
      end
    end
  end

  assign inst       = pd[LATENCY-1];
  assign inst_valid = pv[LATENCY-1];
  assign inst_fault = pf[LATENCY-1];

  // Saturating count of accepted fetches, faulted fetches included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
    end else if (accept && (fetch_cnt != 32'hFFFF_FFFF)) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Testbench for inst_mem_responder. Four instances share one stimulus stream:
//   0: LATENCY=2, BASE=0   1: LATENCY=1, BASE=0
//   2: LATENCY=4, BASE=0   3: LATENCY=2, BASE=0x8000_0000
// Expected responses are queued per instance when a fetch is accepted and are
// popped when the instance raises inst_valid. Each entry carries its due cycle.
module tb_inst_mem_responder;

  localparam int unsigned NI  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int unsigned lat_of(input int unsigned i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [63:0] base_of(input int unsigned i);
    return (i == 3) ? 64'h8000_0000 : 64'h0;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_ena = 1'b0;
  logic [63:0] inst_addr = '0;
  logic        load_ena = 1'b0;
  logic [11:0] load_addr = '0;
  logic [31:0] load_data = '0;

  logic [31:0] inst_w      [NI];
  logic        valid_w     [NI];
  logic        fault_w     [NI];
  logic        stall_w     [NI];
  logic [31:0] fetch_cnt_w [NI];

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      inst_mem_responder #(
        .DEPTH_LOG2(12),
        .LATENCY   (lat_of(g)),
        .BASE_ADDR (base_of(g)),
        .NOP_INST  (NOP)
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .inst_ena  (inst_ena),
        .inst_addr (inst_addr),
        .inst      (inst_w[g]),
        .inst_valid(valid_w[g]),
        .inst_fault(fault_w[g]),
        .load_ena  (load_ena),
        .load_addr (load_addr),
        .load_data (load_data),
        .req_stall (stall_w[g]),
        .fetch_cnt (fetch_cnt_w[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          due;
  } exp_t;

  exp_t        q [NI][$];
  logic [31:0] mdl_mem [4096];
  logic [31:0] mdl_cnt = '0;
  logic [31:0] last_inst [NI];
  int          cyc = 0;

  // Model: judge acceptance and apply loads at each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst && inst_ena && !load_ena) begin
      for (int i = 0; i < NI; i++) begin
        logic [63:0] off;
        exp_t        e;
        off     = inst_addr - base_of(i);
        e.fault = (off[1:0] != 2'b00) || (off >= 64'h4000);
        e.data  = e.fault ? NOP : mdl_mem[off[13:2]];
        e.due   = cyc + int'(lat_of(i)) - 1;
        q[i].push_back(e);
      end
      if (mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 32'd1;
    end
    if (rst && load_ena) mdl_mem[load_addr] = load_data;
  end

  // Monitor: sample outputs mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      string t;
      t = $sformatf("dut%0d", i);
      if (!rst) begin
        check({t, "_rst_inst"}, inst_w[i], 0);
        check({t, "_rst_valid"}, valid_w[i], 0);
        check({t, "_rst_fault"}, fault_w[i], 0);
        check({t, "_rst_cnt"}, fetch_cnt_w[i], 0);
        q[i].delete();
        last_inst[i] = '0;
      end else begin
        while (q[i].size() > 0 && q[i][0].due < cyc) begin
          check({t, "_resp_late"}, cyc, q[i][0].due);
          void'(q[i].pop_front());
        end
        if (valid_w[i]) begin
          if (q[i].size() == 0) begin
            check({t, "_spurious_valid"}, valid_w[i], 0);
          end else begin
            exp_t e;
            e = q[i].pop_front();
            check({t, "_data"}, inst_w[i], e.data);
            check({t, "_fault"}, fault_w[i], e.fault);
            check({t, "_cycle"}, cyc, e.due);
            last_inst[i] = e.data;
          end
        end else begin
          check({t, "_idle_fault"}, fault_w[i], 0);
          check({t, "_idle_hold"}, inst_w[i], last_inst[i]);
        end
        check({t, "_fetch_cnt"}, fetch_cnt_w[i], mdl_cnt);
      end
    end
    if (!rst) mdl_cnt = '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [11:0] a, input logic [31:0] d);
    load_ena  = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_ena  = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] a);
    inst_ena  = 1'b1;
    inst_addr = a;
    tick();
    inst_ena  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with random fetch traffic.
    for (int k = 0; k < 8; k++) begin
      inst_ena  = 1'($urandom_range(0, 1));
      inst_addr = {$urandom, $urandom};
      load_addr = 12'($urandom);
      load_data = $urandom;
      tick();
    end
    inst_ena = 1'b0;
    rst = 1'b1;
    repeat (5) tick();

    // Preload and stream four fetches.
    load_word(12'd0, 32'h0000_0093);
    load_word(12'd1, 32'h0010_0113);
    load_word(12'd2, 32'h0020_0193);
    load_word(12'd3, 32'h0030_0213);
    load_word(12'hFFF, 32'hCAFE_F00D);
    fetch(64'h0);
    fetch(64'h4);
    fetch(64'h8);
    fetch(64'hC);
    repeat (6) tick();
    check("fetch_cnt_stream", fetch_cnt_w[0], 4);

    // Fault paths and range boundaries; dut3 sees base-relative offsets.
    fetch(64'h2);
    fetch(64'h4000);
    fetch(64'h3FFC);
    fetch(64'h0);
    fetch(64'h8000_0004);
    fetch(64'h8000_3FFC);
    repeat (6) tick();

    // Load/fetch collision: fetch refused, then re-presented.
    load_ena  = 1'b1;
    load_addr = 12'd5;
    load_data = 32'hDEAD_BEEF;
    inst_ena  = 1'b1;
    inst_addr = 64'h14;
    #1;
    check("req_stall_collide", stall_w[0], 1);
    tick();
    load_ena = 1'b0;
    #1;
    check("req_stall_clear", stall_w[0], 0);
    tick();
    inst_ena = 1'b0;
    repeat (6) tick();

    // Reset with fetches in flight; RAM must survive.
    fetch(64'h0);
    fetch(64'h4);
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (6) tick();
    fetch(64'h0);
    fetch(64'h14);
    repeat (8) tick();

    for (int i = 0; i < NI; i++) check($sformatf("dut%0d_drain", i), q[i].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
